digit_shift_buffer: RTL and testbench

- Parametrised multi-digit shift register for keypad/launchpad digit entry. Generalises the fixed two-stage 4-bit shifter.
- New digits enter at position 0 and older digits move up. Adds backspace (pop), clear, an occupancy count, full/empty flags and a selectable overflow policy.
- Sits between the key decoder and the display/compare logic. Its flattened digit bus drives the 7-segment multiplexer directly.

---
 rtl/digit_pkg.sv | 36 +++
 rtl/digit_stage.sv | 30 +++
 rtl/digit_shift_buffer.sv | 104 ++++++++++
 tb/tb_digit_shift_buffer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_pkg.sv
// Shared types for the digit shift buffer: digit type, operation encoding, stage mux select.
// Pure declarations; no timing or flow control of its own.
package digit_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPL,
        OP_CLR
    } op_t;

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_BELOW,
        SEL_ABOVE
    } sel_t;

    // A clear reuses the "from above" path with the value forced to zero.
    function automatic sel_t stage_sel(input op_t op, input logic bottom);
        sel_t s;
        s = SEL_HOLD;
        case (op)
            OP_PUSH:        s = SEL_BELOW;
            OP_POP, OP_CLR: s = SEL_ABOVE;
            OP_REPL:        s = bottom ? SEL_BELOW : SEL_HOLD;
            default:        s = SEL_HOLD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/digit_stage.sv
// One digit register with hold / load-from-below / load-from-above-or-zero mux.
// Updates one cycle after en; no backpressure, the stage always accepts its control.
module digit_stage
    import digit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  sel_t             sel,
    input  logic             zero,
    input  logic [WIDTH-1:0] below,
    input  logic [WIDTH-1:0] above,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            q <= '0;
        end else if (en) begin
            case (sel)
                SEL_BELOW: q <= below;
                SEL_ABOVE: q <= zero ? '0 : above;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/digit_shift_buffer.sv
// Multi-digit entry shift buffer with push, backspace, clear, occupancy and overflow policy.
// Single-cycle registered update; never stalls, rejected operations raise a one-cycle err.
module digit_shift_buffer
    import digit_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       Ce,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           Din,
    output logic [DEPTH*WIDTH-1:0]     Dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    op_t              op;
    logic             reject;
    logic [WIDTH-1:0] q [DEPTH];

    assign full  = (count == CNT_MAX);
    assign empty = (count == '0);

    // Priority: clr > push&pop > pop > push. Replace on an empty buffer degrades to a push.
    always_comb begin
        op     = OP_NONE;
        reject = 1'b0;
        if (Ce) begin
            if (clr) begin
                op = OP_CLR;
            end else if (push && pop) begin
                op = empty ? OP_PUSH : OP_REPL;
            end else if (pop) begin
                if (empty) reject = 1'b1;
                else       op     = OP_POP;
            end else if (push) begin
                if (full && SATURATE) reject = 1'b1;
                else                  op     = OP_PUSH;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            err <= reject;
            case (op)
                OP_CLR:  count <= '0;
                OP_PUSH: if (!full) count <= count + CW'(1);
                OP_POP:  count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            logic [WIDTH-1:0] below;
            logic [WIDTH-1:0] above;

            if (i == 0) begin : g_bot
                assign below = Din;
            end else begin : g_mid_b
                assign below = q[i-1];
            end

            // The oldest stage is backfilled with zero so slots at or above count read 0.
            if (i == DEPTH - 1) begin : g_top
                assign above = '0;
            end else begin : g_mid_a
                assign above = q[i+1];
            end

            digit_stage #(
                .WIDTH(WIDTH)
            ) u_stage (
                .CLK   (CLK),
                .RST   (RST),
                .en    (op != OP_NONE),
                .sel   (stage_sel(op, (i == 0))),
                .zero  (op == OP_CLR),
                .below (below),
                .above (above),
                .q     (q[i])
            );

            assign Dout[i*WIDTH +: WIDTH] = q[i];
        end
    endgenerate

endmodule

// File: tb/tb_digit_shift_buffer.sv
module tb_digit_shift_buffer;

    logic        CLK;
    logic        RST;
    logic        Ce;
    logic        push;
    logic        pop;
    logic        clr;
    logic [3:0]  Din;
    logic [15:0] dout0, dout1;
    logic [2:0]  count0, count1;
    logic        full0, full1, empty0, empty1, err0, err1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] dout;
        logic [2:0]  cnt;
        logic        full;
        logic        empty;
        logic        err;
    } snap_t;

    typedef struct packed {
        snap_t s0;
        snap_t s1;
    } pair_t;

    pair_t exp_q[$];
    pair_t act_q[$];

    // Reference model state, index 0 = discard-oldest, 1 = saturating.
    logic [3:0] m_d   [2][4];
    int         m_cnt [2];
    logic       m_err [2];

    digit_shift_buffer #(.WIDTH(4), .DEPTH(4), .SATURATE(1'b0)) dut0 (
        .CLK(CLK), .RST(RST), .Ce(Ce), .push(push), .pop(pop), .clr(clr), .Din(Din),
        .Dout(dout0), .count(count0), .full(full0), .empty(empty0), .err(err0)
    );

    digit_shift_buffer #(.WIDTH(4), .DEPTH(4), .SATURATE(1'b1)) dut1 (
        .CLK(CLK), .RST(RST), .Ce(Ce), .push(push), .pop(pop), .clr(clr), .Din(Din),
        .Dout(dout1), .count(count1), .full(full1), .empty(empty1), .err(err1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic snap_t model_snap(input int s);
        snap_t r;
        r.dout  = {m_d[s][3], m_d[s][2], m_d[s][1], m_d[s][0]};
        r.cnt   = 3'(m_cnt[s]);
        r.full  = (m_cnt[s] == 4);
        r.empty = (m_cnt[s] == 0);
        r.err   = m_err[s];
        return r;
    endfunction

    task automatic model_step(input logic rst_v, ce_v, push_v, pop_v, clr_v, input logic [3:0] din_v);
        for (int s = 0; s < 2; s++) begin
            m_err[s] = 1'b0;
            if (!rst_v || (ce_v && clr_v)) begin
                for (int k = 0; k < 4; k++) m_d[s][k] = 4'h0;
                m_cnt[s] = 0;
            end else if (!ce_v) begin
                // hold
            end else if (push_v && pop_v && m_cnt[s] > 0) begin
                m_d[s][0] = din_v;
            end else if (pop_v && !push_v) begin
                if (m_cnt[s] == 0) m_err[s] = 1'b1;
                else begin
                    for (int k = 0; k < 3; k++) m_d[s][k] = m_d[s][k+1];
                    m_d[s][3] = 4'h0;
                    m_cnt[s]--;
                end
            end else if (push_v) begin
                if (m_cnt[s] == 4 && s == 1) m_err[s] = 1'b1;
                else begin
                    for (int k = 3; k > 0; k--) m_d[s][k] = m_d[s][k-1];
                    m_d[s][0] = din_v;
                    if (m_cnt[s] < 4) m_cnt[s]++;
                end
            end
        end
    endtask

    task automatic drive(input logic rst_v, ce_v, push_v, pop_v, clr_v, input logic [3:0] din_v);
        pair_t e, a;
        @(negedge CLK);
        RST = rst_v; Ce = ce_v; push = push_v; pop = pop_v; clr = clr_v; Din = din_v;
        model_step(rst_v, ce_v, push_v, pop_v, clr_v, din_v);
        e.s0 = model_snap(0);
        e.s1 = model_snap(1);
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        a.s0 = '{dout: dout0, cnt: count0, full: full0, empty: empty0, err: err0};
        a.s1 = '{dout: dout1, cnt: count1, full: full1, empty: empty1, err: err1};
        act_q.push_back(a);
    endtask

    task automatic op_push(input logic [3:0] d); drive(1, 1, 1, 0, 0, d); endtask
    task automatic op_pop();                     drive(1, 1, 0, 1, 0, 4'h0); endtask
    task automatic op_idle();                    drive(1, 1, 0, 0, 0, 4'h0); endtask
    task automatic op_clr();                     drive(1, 1, 0, 0, 1, 4'h0); endtask

    task automatic test_reset();
        pair_t e, a;
        drive(0, 0, 0, 0, 0, 4'h0);
        drive(0, 0, 0, 0, 0, 4'h0);
        checks++;
        if (dout0 !== 16'h0000 || count0 !== 3'd0 || empty0 !== 1'b1 || full0 !== 1'b0 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: dout=%h cnt=%0d empty=%b full=%b err=%b, required 0000/0/1/0/0",
                     dout0, count0, empty0, full0, err0);
        end
        op_push(4'h1); op_push(4'h2); op_push(4'h3);
        drive(0, 1, 0, 0, 0, 4'h0);
        checks++;
        if (dout0 !== 16'h0000 || count0 !== 3'd0 || empty0 !== 1'b1 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_midseq: dout=%h cnt=%0d empty=%b err=%b, required 0000/0/1/0", dout0, count0, empty0, err0);
        end
        drive(0, 1, 1, 0, 0, 4'h5);
        checks++;
        if (dout0 !== 16'h0000 || count0 !== 3'd0) begin
            errors++;
            $display("FAIL reset_over_push: dout=%h cnt=%0d, required 0000/0", dout0, count0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL reset_sb: got %h required %h", a, e); end
        end
    endtask

    task automatic test_fill_overflow();
        pair_t e, a;
        op_clr();
        op_push(4'h1); op_push(4'h2); op_push(4'h3); op_push(4'h4);
        checks++;
        if (dout0 !== 16'h1234 || count0 !== 3'd4 || full0 !== 1'b1 || empty0 !== 1'b0) begin
            errors++;
            $display("FAIL fill: dout=%h cnt=%0d full=%b, required 1234/4/1", dout0, count0, full0);
        end
        drive(1, 0, 1, 0, 0, 4'h7);
        checks++;
        if (dout0 !== 16'h1234 || dout1 !== 16'h1234) begin
            errors++;
            $display("FAIL ce_hold: dout0=%h dout1=%h, required 1234", dout0, dout1);
        end
        op_push(4'h5);
        checks++;
        if (dout0 !== 16'h2345 || count0 !== 3'd4 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL overflow_discard: dout=%h cnt=%0d err=%b, required 2345/4/0", dout0, count0, err0);
        end
        checks++;
        if (dout1 !== 16'h1234 || count1 !== 3'd4 || err1 !== 1'b1) begin
            errors++;
            $display("FAIL overflow_saturate: dout=%h cnt=%0d err=%b, required 1234/4/1", dout1, count1, err1);
        end
        op_idle();
        checks++;
        if (err1 !== 1'b0) begin
            errors++;
            $display("FAIL err_one_cycle: err=%b, required 0", err1);
        end
        op_push(4'h6); op_push(4'h7);
        checks++;
        if (err1 !== 1'b1 || dout1 !== 16'h1234) begin
            errors++;
            $display("FAIL err_back_to_back: err=%b dout=%h, required 1/1234", err1, dout1);
        end
        op_idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL fill_sb: got %h required %h", a, e); end
        end
    endtask

    task automatic test_backspace();
        pair_t e, a;
        op_clr();
        op_push(4'h1); op_push(4'h2); op_push(4'h3); op_push(4'h4);
        op_pop();
        checks++;
        if (dout0 !== 16'h0123 || count0 !== 3'd3) begin
            errors++;
            $display("FAIL pop_one: dout=%h cnt=%0d, required 0123/3", dout0, count0);
        end
        op_pop(); op_pop(); op_pop();
        checks++;
        if (dout0 !== 16'h0000 || count0 !== 3'd0 || empty0 !== 1'b1) begin
            errors++;
            $display("FAIL pop_to_empty: dout=%h cnt=%0d, required 0000/0", dout0, count0);
        end
        op_pop();
        checks++;
        if (dout0 !== 16'h0000 || count0 !== 3'd0 || err0 !== 1'b1 || err1 !== 1'b1) begin
            errors++;
            $display("FAIL pop_underflow: dout=%h cnt=%0d err=%b/%b, required 0000/0/1/1", dout0, count0, err0, err1);
        end
        op_idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL backspace_sb: got %h required %h", a, e); end
        end
    endtask

    task automatic test_simultaneous();
        pair_t e, a;
        op_clr();
        op_push(4'h1); op_push(4'h2); op_push(4'h3);
        drive(1, 1, 1, 1, 0, 4'h9);
        checks++;
        if (dout0 !== 16'h0129 || count0 !== 3'd3 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL replace: dout=%h cnt=%0d err=%b, required 0129/3/0", dout0, count0, err0);
        end
        op_clr();
        drive(1, 1, 1, 1, 0, 4'h6);
        checks++;
        if (dout0 !== 16'h0006 || count0 !== 3'd1 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL replace_empty: dout=%h cnt=%0d err=%b, required 0006/1/0", dout0, count0, err0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL simul_sb: got %h required %h", a, e); end
        end
    endtask

    task automatic test_clear();
        pair_t e, a;
        op_clr();
        op_push(4'h1); op_push(4'h2); op_push(4'h3); op_push(4'h4);
        drive(1, 1, 1, 0, 1, 4'h8);
        checks++;
        if (dout0 !== 16'h0000 || count0 !== 3'd0 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL clr_priority: dout=%h cnt=%0d, required 0000/0", dout0, count0);
        end
        op_push(4'h5);
        drive(1, 0, 0, 0, 1, 4'h0);
        checks++;
        if (dout0 !== 16'h0005 || count0 !== 3'd1) begin
            errors++;
            $display("FAIL clr_ce_low: dout=%h cnt=%0d, required 0005/1", dout0, count0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL clear_sb: got %h required %h", a, e); end
        end
    endtask

    task automatic test_random();
        pair_t e, a;
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 40) != 0), ($urandom_range(0, 5) != 0), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 12) == 0), 4'($urandom));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL random_sb: got %h required %h", a, e); end
        end
    endtask

    initial begin
        RST = 1'b0; Ce = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0; Din = 4'h0;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 4; k++) m_d[s][k] = 4'h0;
            m_cnt[s] = 0;
            m_err[s] = 1'b0;
        end
        test_reset();
        test_fill_overflow();
        test_backspace();
        test_simultaneous();
        test_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
